updown_sweep_controller: RTL

//  Command-driven sequencer for an N-bit synchronous up/down counter datapath.

---
 rtl/sweep_ctrl_pkg.sv | 14 +
 rtl/updown_step_core.sv | 35 +++
 rtl/updown_sweep_controller.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sweep_ctrl_pkg.sv
// Shared encodings for the up/down sweep controller and its count core.
// Pure declarations: no logic, no latency, no flow control.
package sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/updown_step_core.sv
// Loadable WIDTH-bit up/down count register with an end-of-pass compare.
// Latency: load/step take effect at the next rising edge; at_end is combinational on the register.
// Backpressure: none; the controller decides when to load or step.
module updown_step_core
  import sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic             dir,
  input  logic [WIDTH-1:0] end_val,
  output logic [WIDTH-1:0] count,
  output logic             at_end
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (step) begin
      count_q <= (dir == DIR_DOWN) ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
    end
  end

  assign count  = count_q;
  assign at_end = (count_q == end_val);

endmodule

// File: rtl/updown_sweep_controller.sv
// Command-driven bounded up/down sweep sequencer; SWEEP_PINGPONG_EN enables bound-reversal passes.
// Latency: first count one cycle after command acceptance; done/err are registered one-cycle pulses.
// Backpressure: cmd_ready is high only in IDLE; en=0 stalls the sweep, abort cancels it.
module updown_sweep_controller
  import sweep_ctrl_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int REPEAT_W = 4
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [WIDTH-1:0]    cmd_lo,
  input  logic [WIDTH-1:0]    cmd_hi,
  input  logic                cmd_dir,
  input  logic [REPEAT_W-1:0] cmd_reps,
  input  logic                cmd_pingpong,
  input  logic                en,
  input  logic                abort,
  output logic [WIDTH-1:0]    count,
  output logic                count_valid,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_e              state_q;
  logic [WIDTH-1:0]    lo_q, hi_q;
  logic                dir_q;
  logic [REPEAT_W-1:0] passes_q;
  logic                done_q, err_q;

  logic                accept, at_end, last_pass, turn_pp;
  logic                core_load, core_step, core_dir;
  logic [WIDTH-1:0]    core_load_val;

  assign accept    = (state_q == ST_IDLE) && cmd_valid && (cmd_lo <= cmd_hi);
  assign last_pass = (passes_q == REPEAT_W'(1));

`ifdef SWEEP_PINGPONG_EN
  logic pp_q;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      pp_q <= 1'b0;
    end else if (accept) begin
      pp_q <= cmd_pingpong;
    end
  end

  assign turn_pp = pp_q;
`else
  logic pp_unused;
  assign pp_unused = cmd_pingpong;
  assign turn_pp   = 1'b0;
`endif

  // A pingpong turnaround steps straight off the bound it just reached, so a
  // degenerate lo==hi sweep never leaves the single legal value.
  always_comb begin
    core_load     = 1'b0;
    core_load_val = (cmd_dir == DIR_DOWN) ? cmd_hi : cmd_lo;
    core_step     = 1'b0;
    core_dir      = dir_q;
    if (state_q == ST_IDLE) begin
      core_load = accept;
    end else if (state_q == ST_RUN && !abort && en) begin
      if (!at_end) begin
        core_step = 1'b1;
      end else if (!last_pass) begin
        if (turn_pp) begin
          core_step = (lo_q != hi_q);
          core_dir  = ~dir_q;
        end else begin
          core_load     = 1'b1;
          core_load_val = (dir_q == DIR_DOWN) ? hi_q : lo_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= ST_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      dir_q    <= DIR_UP;
      passes_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_lo > cmd_hi) begin
              err_q <= 1'b1;
            end else begin
              lo_q     <= cmd_lo;
              hi_q     <= cmd_hi;
              dir_q    <= cmd_dir;
              passes_q <= (cmd_reps == '0) ? REPEAT_W'(1) : cmd_reps;
              state_q  <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (en && at_end) begin
            if (last_pass) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              passes_q <= passes_q - REPEAT_W'(1);
              if (turn_pp) dir_q <= ~dir_q;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  updown_step_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .clear_n  (clear_n),
    .load     (core_load),
    .load_val (core_load_val),
    .step     (core_step),
    .dir      (core_dir),
    .end_val  ((dir_q == DIR_DOWN) ? lo_q : hi_q),
    .count    (count),
    .at_end   (at_end)
  );

  assign cmd_ready   = (state_q == ST_IDLE);
  assign count_valid = (state_q == ST_RUN);
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done        = done_q;
  assign err         = err_q;

endmodule
